// File: rtl/btn_conditioner.sv
// Debounce, edge-pulse and hold-to-repeat front end for active-low push buttons.
// Latency: 2 clk synchronizer, then accepted on the DEB_MS-th 1 ms tick that disagrees.
// Backpressure: none; every output is a registered level or a 1-clk pulse on a tick cycle.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-high
//   i_sw      raw switches, active-low, asynchronous to clk
//   o_level   debounced state, 1 = pressed
//   o_press   1-clk pulse on accepted press
//   o_release 1-clk pulse on accepted release
//   o_long    1-clk pulse when a hold reaches LONG_MS
//   o_repeat  1-clk pulse every RPT_MS after o_long while held
module btn_conditioner #(
  parameter int CLK_HZ  = 50000000,
  parameter int N_SW    = 4,
  parameter int DEB_MS  = 20,
  parameter int LONG_MS = 1000,
  parameter int RPT_MS  = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_level,
  output logic [N_SW-1:0] o_press,
  output logic [N_SW-1:0] o_release,
  output logic [N_SW-1:0] o_long,
  output logic [N_SW-1:0] o_repeat
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TICK_W   = $clog2(TICK_DIV);
  // +1 keeps each width >= 1 even when the terminal count is 0
  localparam int DEB_W    = $clog2(DEB_MS + 1);
  localparam int HOLD_W   = $clog2(LONG_MS + 1);
  localparam int RPT_W    = $clog2(RPT_MS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // 1 ms clock-enable
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // 2-FF synchronizer on the inverted inputs so 1 means pressed downstream
  logic [N_SW-1:0] sync_q1;
  logic [N_SW-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_p  <= '0;
    end else begin
      sync_q1 <= ~i_sw;
      sync_p  <= sync_q1;
    end
  end

  logic [DEB_W-1:0]  deb_cnt  [N_SW];
  logic [HOLD_W-1:0] hold_cnt [N_SW];
  logic [RPT_W-1:0]  rpt_cnt  [N_SW];
  logic [1:0]        state    [N_SW];
  logic [N_SW-1:0]   accept;

  // A level change is taken on the DEB_MS-th consecutive disagreeing tick
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_SW; i++) begin
      accept[i] = tick && (sync_p[i] != o_level[i]) &&
                  (deb_cnt[i] == DEB_W'(DEB_MS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_level   <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_long    <= '0;
      o_repeat  <= '0;
      for (int i = 0; i < N_SW; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
        rpt_cnt[i]  <= '0;
        state[i]    <= ST_IDLE;
      end
    end else begin
      o_press   <= '0;
      o_release <= '0;
      o_long    <= '0;
      o_repeat  <= '0;
      if (tick) begin
        for (int i = 0; i < N_SW; i++) begin
          // debounce
          if (accept[i]) begin
            deb_cnt[i] <= '0;
            o_level[i] <= sync_p[i];
          end else if (sync_p[i] != o_level[i]) begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end else begin
            deb_cnt[i] <= '0;
          end

          // hold / repeat; an accepted edge overrides the FSM so a release
          // never coincides with o_long or o_repeat
          if (accept[i]) begin
            if (sync_p[i]) begin
              o_press[i]  <= 1'b1;
              state[i]    <= ST_HELD;
              hold_cnt[i] <= '0;
            end else begin
              o_release[i] <= 1'b1;
              state[i]     <= ST_IDLE;
            end
          end else begin
            case (state[i])
              ST_IDLE: ;
              ST_HELD: begin
                // hold_cnt reaches LONG_MS on this tick
                if (hold_cnt[i] == HOLD_W'(LONG_MS - 1)) begin
                  o_long[i]  <= 1'b1;
                  state[i]   <= ST_LONG;
                  rpt_cnt[i] <= '0;
                end else begin
                  hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
              end
              ST_LONG: begin
                if (rpt_cnt[i] == RPT_W'(RPT_MS - 1)) begin
                  o_repeat[i] <= 1'b1;
                  rpt_cnt[i]  <= '0;
                end else begin
                  rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
              end
              default: state[i] <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioner for the four clock-setting push buttons (mode, position, increment, alarm-enable).
- Sits directly upstream of the clock controller. Takes raw, bouncing, active-low switch inputs and produces clean level signals plus single-clk event pulses, all synchronous to the system clock.
- Hold-to-repeat on every switch, so the controller can auto-increment minutes and seconds while a button is held.
- Replaces the free-running 100 Hz sampling-clock scheme with a clock-enable tick; no derived clocks.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz. CLK_HZ/1000 must be >= 2.
- N_SW, 4, number of switches handled.
- DEB_MS, 20, consecutive 1 ms samples needed to accept a level change (>= 1).
- LONG_MS, 1000, hold time in ms from accepted press to o_long (> DEB_MS).
- RPT_MS, 200, o_repeat period in ms after o_long (>= 1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- i_sw  input  N_SW  raw switches, active-low (0 = pressed), asynchronous to clk.
- o_level  output  N_SW  debounced state, 1 = pressed.
- o_press  output  N_SW  1-clk pulse on accepted press.
- o_release  output  N_SW  1-clk pulse on accepted release.
- o_long  output  N_SW  1-clk pulse when hold reaches LONG_MS.
- o_repeat  output  N_SW  1-clk pulse every RPT_MS after o_long while held.

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs, synchronizers, debounce/hold/repeat counters and the tick counter are cleared to 0.
  - Synchronizer flops reset to "not pressed".
- Synchronizer: 2-FF per bit on ~i_sw; 2-clk latency to sync_p[i].
- Tick generator: tick_cnt counts 0..CLK_HZ/1000-1 and wraps. tick=1 for the single clk where tick_cnt==CLK_HZ/1000-1. The first tick falls CLK_HZ/1000 clks after rst deasserts.
- Per-switch debounce, evaluated only on tick cycles:
  - If sync_p != o_level and deb_cnt==DEB_MS-1: toggle o_level, clear deb_cnt, and pulse o_press (0->1) or o_release (1->0) on the same clk edge that o_level changes.
  - Else if sync_p != o_level: deb_cnt++.
  - Else: deb_cnt=0. Any bounce back restarts the count.
  - Net effect: a change is accepted on the DEB_MS-th consecutive differing tick sample.
- Per-switch hold FSM (states IDLE, HELD, LONG):
  - IDLE -> HELD on accepted press; hold_cnt=0.
  - HELD: hold_cnt++ each tick. When hold_cnt reaches LONG_MS: pulse o_long, go to LONG, clear rpt_cnt.
  - LONG: rpt_cnt++ each tick. When rpt_cnt reaches RPT_MS: pulse o_repeat, rpt_cnt=0. Repeats continue indefinitely while o_level=1.
  - Any state -> IDLE on accepted release, in the same cycle as o_release. No o_long or o_repeat is issued in that cycle or afterwards.
  - While a release is being debounced, o_level stays 1 and repeat pulses continue.
- Pulse timing: every pulse is high for exactly 1 clk, coincident with a tick cycle. Pulses are registered outputs.
- Independence: switches are fully independent. Simultaneous events on several bits assert their pulses in the same clk. The o_press bit for a switch is never high in the same clk as that switch's o_release, o_long or o_repeat.
- Counter widths: sized with $clog2 of their maximum values. hold_cnt and rpt_cnt cannot overflow, because each is cleared or stops at its terminal value.
- Reset mid-operation: all state is discarded. A switch still held after reset is re-detected as a fresh press once DEB_MS ticks elapse after the pipeline refills; o_press then fires again.

Test Plan (CLK_HZ=10000 so tick = 10 clks, DEB_MS=3, LONG_MS=10, RPT_MS=4, N_SW=4):
- Clean press: i_sw[0] held low from 20 clks after reset -> o_level[0] rises and o_press[0] pulses exactly once, on the 3rd tick that samples sync_p[0]=1; other bits stay 0.
- Bounce: i_sw[1] low for 2 ticks, high for 1 tick, then low steady -> no pulse until 3 further consecutive low ticks; then exactly one o_press[1].
- Long hold: hold i_sw[2] for 25 ticks past the press -> o_long[2] 10 ticks after o_press, o_repeat[2] at +14, +18, +22 ticks; release -> o_release[2] on the 3rd high tick, o_level[2]=0, no further repeats.
- Release before long: i_sw[3] pressed, then released after 5 ticks -> o_press then o_release; o_long and o_repeat never pulse.
- Simultaneous press: i_sw[0] and i_sw[2] fall in the same clk -> o_press=4'b0101 in one clk, with o_level updating together.
- Reset mid-hold: rst=1 for 1 clk during LONG with i_sw[0] still low -> all outputs 0 the following clk; first tick 10 clks after rst drops; o_press[0] fires again at the 3rd tick that samples the switch pressed.
